// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// NRD combinational read ports, two byte-strobed write ports (port 1 wins on
// overlapping bytes), optional hardwired-zero register 0 and optional
// write-to-read bypass so a reader sees the post-edge value in the same cycle.
module regfile_mp #(
   parameter  int XLEN     = 32,
   parameter  int NREGS    = 32,
   parameter  int NRD      = 2,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(NREGS),
   localparam int BW       = XLEN / 8
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic                wrtEn0,
   input  logic [AW-1:0]       wrtReg0,
   input  logic [XLEN-1:0]     wrtData0,
   input  logic [BW-1:0]       wrtBe0,
   input  logic                wrtEn1,
   input  logic [AW-1:0]       wrtReg1,
   input  logic [XLEN-1:0]     wrtData1,
   input  logic [BW-1:0]       wrtBe1,
   input  logic [NRD*AW-1:0]   rdReg,
   output logic [NRD*XLEN-1:0] rdData
);

   logic [XLEN-1:0] regs [NREGS];

   // Value a register holds after this edge: the stored word with port 0's
   // strobed bytes applied, then port 1's on top. Writes to a hardwired-zero
   // register 0 are dropped. Shared by the array update and the bypass path so
   // the forwarded value can never disagree with what is stored.
   function automatic logic [XLEN-1:0] merge_word(
      input logic [XLEN-1:0] old,
      input logic [AW-1:0]   addr,
      input logic            en0,
      input logic [AW-1:0]   a0,
      input logic [XLEN-1:0] d0,
      input logic [BW-1:0]   be0,
      input logic            en1,
      input logic [AW-1:0]   a1,
      input logic [XLEN-1:0] d1,
      input logic [BW-1:0]   be1
   );
      logic [XLEN-1:0] w;
      logic            is_zero;
      logic            hit0;
      logic            hit1;
      is_zero = (ZERO_REG != 0) && (addr == '0);
      hit0    = en0 && (a0 == addr) && !is_zero;
      hit1    = en1 && (a1 == addr) && !is_zero;
      w       = old;
      for (int i = 0; i < BW; i++) begin
         if (hit0 && be0[i]) w[8*i +: 8] = d0[8*i +: 8];
         if (hit1 && be1[i]) w[8*i +: 8] = d1[8*i +: 8];
      end
      return w;
   endfunction

   // Register array update: synchronous clear, otherwise byte-merged writes.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREGS; r++) begin
         // NOTE: the array is built from flops rather than a RAM macro, so every
         // entry is cleared on reset; a RAM-based file could not do this in one edge.
         if (!rst_) begin
            regs[r] <= '0;
         end else begin
            // NOTE: state is updated with <= so every entry samples the pre-edge
            // array, independent of loop order.
            regs[r] <= merge_word(regs[r], AW'(r),
                                  wrtEn0, wrtReg0, wrtData0, wrtBe0,
                                  wrtEn1, wrtReg1, wrtData1, wrtBe1);
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] word;

      assign addr = rdReg[k*AW +: AW];

      // Read lane k: forced 0 in reset and for register 0, else stored or bypassed.
      always_comb begin
         // NOTE: default first so no path through this block leaves word unassigned
         // (which would infer a latch).
         word = '0;
         if (!rst_) begin
            word = '0;
         end else if ((ZERO_REG != 0) && (addr == '0)) begin
            word = '0;
         end else if (BYPASS != 0) begin
            word = merge_word(regs[addr], addr,
                              wrtEn0, wrtReg0, wrtData0, wrtBe0,
                              wrtEn1, wrtReg1, wrtData1, wrtBe1);
         end else begin
            word = regs[addr];
         end
      end

      assign rdData[k*XLEN +: XLEN] = word;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp. Two instances share all
// inputs, one with bypass and one without, so each stimulus cycle checks the
// same-cycle (post-edge) and registered (pre-edge) read behaviour together.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;
   localparam int BW    = 4;

   logic                clk = 1'b0;
   logic                rst_;
   logic                wrtEn0;
   logic [AW-1:0]       wrtReg0;
   logic [XLEN-1:0]     wrtData0;
   logic [BW-1:0]       wrtBe0;
   logic                wrtEn1;
   logic [AW-1:0]       wrtReg1;
   logic [XLEN-1:0]     wrtData1;
   logic [BW-1:0]       wrtBe1;
   logic [NRD*AW-1:0]   rdReg;
   logic [NRD*XLEN-1:0] rd_data_byp;
   logic [NRD*XLEN-1:0] rd_data_nb;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut_byp (
      .clk(clk), .rst_(rst_),
      .wrtEn0(wrtEn0), .wrtReg0(wrtReg0), .wrtData0(wrtData0), .wrtBe0(wrtBe0),
      .wrtEn1(wrtEn1), .wrtReg1(wrtReg1), .wrtData1(wrtData1), .wrtBe1(wrtBe1),
      .rdReg(rdReg), .rdData(rd_data_byp)
   );

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_(rst_),
      .wrtEn0(wrtEn0), .wrtReg0(wrtReg0), .wrtData0(wrtData0), .wrtBe0(wrtBe0),
      .wrtEn1(wrtEn1), .wrtReg1(wrtReg1), .wrtData1(wrtData1), .wrtBe1(wrtBe1),
      .rdReg(rdReg), .rdData(rd_data_nb)
   );

   // Scoreboard entry: which instance (0 = bypass, 1 = no bypass), which lane,
   // and the value that lane must show before the next rising edge.
   typedef struct {
      string           name;
      int              dut;
      int              lane;
      logic [XLEN-1:0] exp;
   } sb_item_t;

   // One table row: a full cycle of inputs plus expected lane values.
   typedef struct {
      logic            en0;
      logic [AW-1:0]   r0;
      logic [XLEN-1:0] d0;
      logic [BW-1:0]   be0;
      logic            en1;
      logic [AW-1:0]   r1;
      logic [XLEN-1:0] d1;
      logic [BW-1:0]   be1;
      logic [AW-1:0]   ra;
      logic [AW-1:0]   rb;
      logic [XLEN-1:0] byp_a;
      logic [XLEN-1:0] byp_b;
      logic [XLEN-1:0] nb_a;
      logic [XLEN-1:0] nb_b;
   } vec_t;

   sb_item_t        sb_q[$];
   vec_t            vecs[14];
   logic [XLEN-1:0] ref_regs[NREGS];
   logic [XLEN-1:0] ref_next[NREGS];
   int              n_checks = 0;
   int              n_fail   = 0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_rd(input string name, input int dut, input int lane, input logic [XLEN-1:0] exp);
      sb_item_t it;
      it.name = name;
      it.dut  = dut;
      it.lane = lane;
      it.exp  = exp;
      sb_q.push_back(it);
   endtask

   // Sample on the falling edge, drain the scoreboard, then step past the next
   // rising edge so new inputs are driven away from it.
   task automatic settle_and_tick();
      sb_item_t        it;
      logic [XLEN-1:0] act;
      @(negedge clk);
      while (sb_q.size() > 0) begin
         it  = sb_q.pop_front();
         act = (it.dut == 0) ? rd_data_byp[it.lane*XLEN +: XLEN] : rd_data_nb[it.lane*XLEN +: XLEN];
         check(it.name, act, it.exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en0, input logic [AW-1:0] r0, input logic [XLEN-1:0] d0,
                        input logic [BW-1:0] be0, input logic en1, input logic [AW-1:0] r1,
                        input logic [XLEN-1:0] d1, input logic [BW-1:0] be1,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      wrtEn0   = en0;  wrtReg0 = r0;  wrtData0 = d0;  wrtBe0 = be0;
      wrtEn1   = en1;  wrtReg1 = r1;  wrtData1 = d1;  wrtBe1 = be1;
      rdReg    = {rb, ra};
   endtask

   function automatic vec_t mk(input logic en0, input logic [AW-1:0] r0, input logic [XLEN-1:0] d0,
                               input logic [BW-1:0] be0, input logic en1, input logic [AW-1:0] r1,
                               input logic [XLEN-1:0] d1, input logic [BW-1:0] be1,
                               input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                               input logic [XLEN-1:0] byp_a, input logic [XLEN-1:0] byp_b,
                               input logic [XLEN-1:0] nb_a, input logic [XLEN-1:0] nb_b);
      vec_t v;
      v.en0 = en0; v.r0 = r0; v.d0 = d0; v.be0 = be0;
      v.en1 = en1; v.r1 = r1; v.d1 = d1; v.be1 = be1;
      v.ra = ra; v.rb = rb;
      v.byp_a = byp_a; v.byp_b = byp_b; v.nb_a = nb_a; v.nb_b = nb_b;
      return v;
   endfunction

   initial begin
      // Directed sequence starting from an all-zero file. Bypass columns are the
      // post-edge value, no-bypass columns the pre-edge value.
      //            en0 r0  d0            be0      en1 r1 d1            be1      ra  rb  byp_a         byp_b         nb_a          nb_b
      vecs[0]  = mk(1, 15, 32'h000000FF, 4'hF,    0, 0, 32'h0,         4'h0,    15, 10, 32'h000000FF, 32'h0,        32'h0,        32'h0);
      vecs[1]  = mk(1, 10, 32'h00000045, 4'hF,    0, 0, 32'h0,         4'h0,    15, 10, 32'h000000FF, 32'h00000045, 32'h000000FF, 32'h0);
      vecs[2]  = mk(0, 10, 32'h00000099, 4'hF,    0, 0, 32'h0,         4'h0,    10, 15, 32'h00000045, 32'h000000FF, 32'h00000045, 32'h000000FF);
      vecs[3]  = mk(1, 14, 32'h11223344, 4'hF,    0, 0, 32'h0,         4'h0,    14, 14, 32'h11223344, 32'h11223344, 32'h0,        32'h0);
      vecs[4]  = mk(1, 14, 32'hAABBCCDD, 4'b0101, 0, 0, 32'h0,         4'h0,    14, 0,  32'h11BB33DD, 32'h0,        32'h11223344, 32'h0);
      vecs[5]  = mk(0, 0,  32'h0,        4'h0,    0, 0, 32'h0,         4'h0,    14, 14, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
      vecs[6]  = mk(1, 5,  32'h12345678, 4'hF,    1, 5, 32'h9ABCDEF0,  4'b0011, 5,  5,  32'h1234DEF0, 32'h1234DEF0, 32'h0,        32'h0);
      vecs[7]  = mk(1, 1,  32'h00006789, 4'hF,    0, 0, 32'h0,         4'h0,    5,  1,  32'h1234DEF0, 32'h00006789, 32'h1234DEF0, 32'h0);
      vecs[8]  = mk(0, 0,  32'h0,        4'h0,    0, 0, 32'h0,         4'h0,    1,  5,  32'h00006789, 32'h1234DEF0, 32'h00006789, 32'h1234DEF0);
      vecs[9]  = mk(1, 0,  32'hFFFFFFFF, 4'hF,    1, 0, 32'h00000012,  4'hF,    0,  0,  32'h0,        32'h0,        32'h0,        32'h0);
      vecs[10] = mk(0, 0,  32'h0,        4'h0,    0, 0, 32'h0,         4'h0,    0,  1,  32'h0,        32'h00006789, 32'h0,        32'h00006789);
      vecs[11] = mk(1, 7,  32'hFFFFFFFF, 4'h0,    1, 8, 32'hCAFEF00D,  4'b1100, 7,  8,  32'h0,        32'hCAFE0000, 32'h0,        32'h0);
      vecs[12] = mk(1, 8,  32'h0000BEEF, 4'b0011, 1, 8, 32'h11110000,  4'b0100, 8,  8,  32'hCA11BEEF, 32'hCA11BEEF, 32'hCAFE0000, 32'hCAFE0000);
      vecs[13] = mk(0, 0,  32'h0,        4'h0,    0, 0, 32'h0,         4'h0,    8,  7,  32'hCA11BEEF, 32'h0,        32'hCA11BEEF, 32'h0);

      // Reset with a write pending: lanes read 0 while reset is held.
      rst_ = 1'b0;
      drive(1, 3, 32'hDEADBEEF, 4'hF, 1, 3, 32'hDEADBEEF, 4'hF, 3, 3);
      #1;
      for (int l = 0; l < NRD; l++) begin
         expect_rd($sformatf("in_reset_byp_l%0d", l), 0, l, 32'h0);
         expect_rd($sformatf("in_reset_nb_l%0d", l), 1, l, 32'h0);
      end
      settle_and_tick();

      // Scan every address through every lane.
      rst_ = 1'b1;
      for (int a = 0; a < NREGS; a++) begin
         drive(0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0, AW'(a), AW'(a));
         for (int l = 0; l < NRD; l++) begin
            expect_rd($sformatf("scan%0d_byp_l%0d", a, l), 0, l, 32'h0);
            expect_rd($sformatf("scan%0d_nb_l%0d", a, l), 1, l, 32'h0);
         end
         settle_and_tick();
      end

      // Table-driven directed vectors.
      for (int v = 0; v < 14; v++) begin
         drive(vecs[v].en0, vecs[v].r0, vecs[v].d0, vecs[v].be0,
               vecs[v].en1, vecs[v].r1, vecs[v].d1, vecs[v].be1, vecs[v].ra, vecs[v].rb);
         expect_rd($sformatf("vec%0d_byp_l0", v), 0, 0, vecs[v].byp_a);
         expect_rd($sformatf("vec%0d_byp_l1", v), 0, 1, vecs[v].byp_b);
         expect_rd($sformatf("vec%0d_nb_l0", v),  1, 0, vecs[v].nb_a);
         expect_rd($sformatf("vec%0d_nb_l1", v),  1, 1, vecs[v].nb_b);
         settle_and_tick();
      end

      // Reset mid-write on a populated file: lanes forced 0, then everything cleared.
      rst_ = 1'b0;
      drive(1, 3, 32'h00000055, 4'hF, 0, 0, 32'h0, 4'h0, 3, 8);
      #1;
      expect_rd("rst_mid_byp_l0", 0, 0, 32'h0);
      expect_rd("rst_mid_byp_l1", 0, 1, 32'h0);
      expect_rd("rst_mid_nb_l0",  1, 0, 32'h0);
      expect_rd("rst_mid_nb_l1",  1, 1, 32'h0);
      settle_and_tick();
      rst_ = 1'b1;
      drive(0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0, 3, 8);
      expect_rd("post_rst_r3_byp", 0, 0, 32'h0);
      expect_rd("post_rst_r8_byp", 0, 1, 32'h0);
      expect_rd("post_rst_r3_nb",  1, 0, 32'h0);
      expect_rd("post_rst_r8_nb",  1, 1, 32'h0);
      settle_and_tick();

      // Random traffic on a small address window so collisions are frequent,
      // checked against a byte-level reference model of the file.
      for (int r = 0; r < NREGS; r++) ref_regs[r] = '0;
      for (int c = 0; c < 200; c++) begin
         logic            en0, en1;
         logic [AW-1:0]   r0, r1, ra, rb;
         logic [XLEN-1:0] d0, d1;
         logic [BW-1:0]   be0, be1;
         en0 = 1'($urandom_range(0, 1));
         en1 = 1'($urandom_range(0, 1));
         r0  = AW'($urandom_range(0, 7));
         r1  = AW'($urandom_range(0, 7));
         ra  = AW'($urandom_range(0, 7));
         rb  = AW'($urandom_range(0, 7));
         d0  = $urandom;
         d1  = $urandom;
         be0 = BW'($urandom);
         be1 = BW'($urandom);
         ref_next = ref_regs;
         for (int i = 0; i < BW; i++) begin
            if (en0 && r0 != 0 && be0[i]) ref_next[r0][8*i +: 8] = d0[8*i +: 8];
         end
         for (int i = 0; i < BW; i++) begin
            if (en1 && r1 != 0 && be1[i]) ref_next[r1][8*i +: 8] = d1[8*i +: 8];
         end
         drive(en0, r0, d0, be0, en1, r1, d1, be1, ra, rb);
         expect_rd($sformatf("rnd%0d_byp_l0", c), 0, 0, ref_next[ra]);
         expect_rd($sformatf("rnd%0d_byp_l1", c), 0, 1, ref_next[rb]);
         expect_rd($sformatf("rnd%0d_nb_l0", c),  1, 0, ref_regs[ra]);
         expect_rd($sformatf("rnd%0d_nb_l1", c),  1, 1, ref_regs[rb]);
         settle_and_tick();
         ref_regs = ref_next;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
